// File: rtl/multi_dig_svn_seg_display.sv
// Multiplexed seven-segment display driver.
// Scans NUM_DIG digits, one slot of REFRESH_DIV clocks per digit. Brightness is
// PWM within each slot. Leading zeros can be suppressed. New digit data is
// double-buffered so that it only changes at a frame boundary.
module multi_dig_svn_seg_display #(
    parameter int NUM_DIG     = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [4*NUM_DIG-1:0]  digits,
    input  logic [NUM_DIG-1:0]    dp,
    input  logic [NUM_DIG-1:0]    blank,
    input  logic                  lz_sup,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  load,
    output logic [NUM_DIG-1:0]    an,
    output logic [6:0]            ca,
    output logic                  dp_out,
    output logic                  frame_done
);

    localparam int RCNT_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W    = $clog2(NUM_DIG);
    localparam int SLOT_LEN = REFRESH_DIV >> BRIGHT_W;
    localparam int PH_W     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIG - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SLOT_LEN - 1);

    // Scan state. sub_reg tracks rcnt / SLOT_LEN incrementally, so no divider
    // is needed: ph_reg counts within one brightness sub-slot.
    logic [RCNT_W-1:0]   rcnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [PH_W-1:0]     ph_reg;
    logic [BRIGHT_W-1:0] sub_reg;

    // Pending (shadow) and active digit sets.
    logic [4*NUM_DIG-1:0] pend_dig_reg;
    logic [NUM_DIG-1:0]   pend_dp_reg;
    logic [NUM_DIG-1:0]   pend_blk_reg;
    logic                 pend_v_reg;
    logic [4*NUM_DIG-1:0] act_dig_reg;
    logic [NUM_DIG-1:0]   act_dp_reg;
    logic [NUM_DIG-1:0]   act_blk_reg;
    // Cleared by reset: the display stays dark until the first set of data has
    // been transferred to the active set at a frame boundary.
    logic                 act_v_reg;

    logic slot_end;
    logic frame_end;

    logic [NUM_DIG-1:0] zero_above;
    logic [NUM_DIG-1:0] supp;
    logic [NUM_DIG-1:0] glyph_off;
    logic [NUM_DIG-1:0] dark;

    logic [3:0]         cur_dig;
    logic               lit;
    logic [NUM_DIG-1:0] an_next;
    logic [6:0]         ca_next;
    logic               dp_out_next;

    logic [NUM_DIG-1:0] an_reg;
    logic [6:0]         ca_reg;
    logic               dp_out_reg;
    logic               frame_done_reg;

    assign slot_end  = (rcnt_reg == RCNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Refresh counter, digit index and brightness sub-slot counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rcnt_reg <= '0;
            idx_reg  <= '0;
            ph_reg   <= '0;
            sub_reg  <= '0;
        end else begin
            rcnt_reg <= slot_end ? '0 : rcnt_reg + 1'b1;
            if (slot_end) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                ph_reg  <= '0;
                sub_reg <= '0;
            end else if (ph_reg == PH_LAST) begin
                ph_reg  <= '0;
                sub_reg <= sub_reg + 1'b1;
            end else begin
                ph_reg  <= ph_reg + 1'b1;
            end
        end
    end

    // Double buffer: loads land in the pending set; the active set only changes
    // at a frame boundary. A load in the boundary cycle bypasses straight to
    // the active set and supersedes anything still pending.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_dig_reg <= '0;
            pend_dp_reg  <= '0;
            pend_blk_reg <= '0;
            pend_v_reg   <= 1'b0;
            act_dig_reg  <= '0;
            act_dp_reg   <= '0;
            act_blk_reg  <= '0;
            act_v_reg    <= 1'b0;
        end else begin
            if (load) begin
                pend_dig_reg <= digits;
                pend_dp_reg  <= dp;
                pend_blk_reg <= blank;
            end
            if (frame_end) begin
                if (load) begin
                    act_dig_reg <= digits;
                    act_dp_reg  <= dp;
                    act_blk_reg <= blank;
                    act_v_reg   <= 1'b1;
                    pend_v_reg  <= 1'b0;
                end else if (pend_v_reg) begin
                    act_dig_reg <= pend_dig_reg;
                    act_dp_reg  <= pend_dp_reg;
                    act_blk_reg <= pend_blk_reg;
                    act_v_reg   <= 1'b1;
                    pend_v_reg  <= 1'b0;
                end
            end else if (load) begin
                pend_v_reg <= 1'b1;
            end
        end
    end

    // Per-digit blanking. A zero-suppressed digit hides its glyph, but keeps its
    // anode on when it requests a decimal point so that "0.5"-style values can
    // still show the point; a force-blanked digit is always fully dark.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            assign zero_above[gi] = (act_dig_reg[4*NUM_DIG-1:4*gi] == '0);
            if (gi == 0) begin : g_first
                assign supp[gi] = 1'b0;
            end else begin : g_rest
                assign supp[gi] = lz_sup & zero_above[gi];
            end
            assign glyph_off[gi] = ~act_v_reg | act_blk_reg[gi] | supp[gi];
            assign dark[gi]      = ~act_v_reg | act_blk_reg[gi] | (supp[gi] & ~act_dp_reg[gi]);
        end
    endgenerate

    // Next output values from the current scan state; rcnt==0 is a dark
    // anti-ghosting cycle at the start of every slot.
    always_comb begin
        cur_dig     = act_dig_reg[4*idx_reg +: 4];
        lit         = (rcnt_reg != '0) && (sub_reg < bright) && !dark[idx_reg];
        an_next     = '1;
        ca_next     = 7'b1111111;
        dp_out_next = 1'b1;
        if (lit) begin
            an_next[idx_reg] = 1'b0;
            dp_out_next      = ~act_dp_reg[idx_reg];
            if (!glyph_off[idx_reg]) begin
                ca_next = hex_to_seg(cur_dig);
            end
        end
    end

    // Registered outputs; reset drives them inactive without waiting for clk.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an_reg         <= '1;
            ca_reg         <= 7'b1111111;
            dp_out_reg     <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            ca_reg         <= ca_next;
            dp_out_reg     <= dp_out_next;
            frame_done_reg <= frame_end;
        end
    end

    assign an         = an_reg;
    assign ca         = ca_reg;
    assign dp_out     = dp_out_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_multi_dig_svn_seg_display.sv
// Bench for multi_dig_svn_seg_display with NUM_DIG=4, REFRESH_DIV=16, BRIGHT_W=2
// (16-cycle slots, 64-cycle frames). cyc counts clock edges since reset
// release; the outputs seen after edge n describe scan state n-1, where
// rcnt = (n-1)%16 and idx = ((n-1)/16)%4.
module tb_multi_dig_svn_seg_display;

    logic        clk;
    logic        clr_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_sup;
    logic [1:0]  bright;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dp_out;
    logic        frame_done;

    int pass_cnt;
    int total_cnt;
    int cyc;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dpv;
        logic [3:0]  blk;
        logic        lz;
        logic [1:0]  br;
        int          s;
        int          r;
        logic [3:0]  exp_an;
        logic [6:0]  exp_ca;
        logic        exp_dp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0001110;

    multi_dig_svn_seg_display #(
        .NUM_DIG    (4),
        .REFRESH_DIV(16),
        .BRIGHT_W   (2)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .digits    (digits),
        .dp        (dp),
        .blank     (blank),
        .lz_sup    (lz_sup),
        .bright    (bright),
        .load      (load),
        .an        (an),
        .ca        (ca),
        .dp_out    (dp_out),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got %h as expected (cyc %0d)", nm, act, exp, cyc);
        end else begin
            $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input logic [15:0] dig, input logic [3:0] dpv, input logic [3:0] blk,
                           input logic lz, input logic [1:0] br, input int s, input int r,
                           input logic [3:0] ea, input logic [6:0] ec, input logic ed);
        vec_t v;
        v.dig = dig; v.dpv = dpv; v.blk = blk; v.lz = lz; v.br = br;
        v.s = s; v.r = r; v.exp_an = ea; v.exp_ca = ec; v.exp_dp = ed;
        vecs.push_back(v);
    endtask

    // Drive a load in the current cycle and return the first scan state of the
    // frame in which the loaded data becomes active.
    task automatic do_load(input logic [15:0] dig, input logic [3:0] dpv, input logic [3:0] blk,
                           output int fs);
        int n;
        n      = cyc;
        digits = dig; dp = dpv; blank = blk;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        fs     = n - (n % 64) + 64;
    endtask

    initial begin
        int fs;
        int bad;
        int pulses;

        pass_cnt = 0; total_cnt = 0; cyc = 0;
        clr_n = 1'b0; digits = 16'h1234; dp = 4'h0; blank = 4'h0;
        lz_sup = 1'b0; bright = 2'd3; load = 1'b1;

        // Reset values held while clr_n is low, even with load asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {3'b0, an, ca, dp_out, frame_done}, {3'b0, 4'b1111, OFF, 1'b1, 1'b0});
        load = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;

        // digits, dp, blank, lz, bright, slot, rcnt, an, ca, dp_out
        add_vec(16'h1234, 4'h0, 4'h0, 0, 3, 0, 1,  4'b1110, S4,  1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 3, 0, 11, 4'b1110, S4,  1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 3, 0, 0,  4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 3, 0, 12, 4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 3, 1, 5,  4'b1101, S3,  1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 3, 3, 1,  4'b0111, S1,  1);
        add_vec(16'h0050, 4'h0, 4'h0, 1, 3, 3, 5,  4'b1111, OFF, 1);
        add_vec(16'h0050, 4'h0, 4'h0, 1, 3, 2, 5,  4'b1111, OFF, 1);
        add_vec(16'h0050, 4'h0, 4'h0, 1, 3, 1, 5,  4'b1101, S5,  1);
        add_vec(16'h0050, 4'h0, 4'h0, 1, 3, 0, 5,  4'b1110, S0,  1);
        add_vec(16'h0000, 4'h0, 4'h0, 1, 3, 0, 5,  4'b1110, S0,  1);
        add_vec(16'h0000, 4'h0, 4'h0, 1, 3, 1, 5,  4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 0, 0, 5,  4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 1, 0, 3,  4'b1110, S4,  1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 1, 0, 4,  4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 2, 0, 7,  4'b1110, S4,  1);
        add_vec(16'h1234, 4'h0, 4'h0, 0, 2, 0, 8,  4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h5, 4'h4, 0, 3, 2, 5,  4'b1111, OFF, 1);
        add_vec(16'h1234, 4'h5, 4'h4, 0, 3, 0, 5,  4'b1110, S4,  0);
        add_vec(16'h1234, 4'h5, 4'h4, 0, 3, 1, 5,  4'b1101, S3,  1);
        add_vec(16'hF8A0, 4'h0, 4'h0, 0, 3, 1, 2,  4'b1101, SA,  1);
        add_vec(16'hF8A0, 4'h0, 4'h0, 0, 3, 2, 2,  4'b1011, S8,  1);
        add_vec(16'hF8A0, 4'h0, 4'h0, 0, 3, 3, 2,  4'b0111, SF,  1);
        add_vec(16'hF8A0, 4'h0, 4'h0, 0, 3, 0, 2,  4'b1110, S0,  1);
        add_vec(16'h0050, 4'h8, 4'h0, 1, 3, 3, 5,  4'b0111, OFF, 0);
        add_vec(16'h0050, 4'h8, 4'h8, 1, 3, 3, 5,  4'b1111, OFF, 1);
        add_vec(16'h0050, 4'h0, 4'h0, 0, 3, 3, 5,  4'b0111, S0,  1);

        foreach (vecs[i]) begin
            lz_sup = vecs[i].lz;
            bright = vecs[i].br;
            do_load(vecs[i].dig, vecs[i].dpv, vecs[i].blk, fs);
            wait_until(fs + vecs[i].s * 16 + vecs[i].r + 1);
            chk($sformatf("vec%0d_s%0d_r%0d", i, vecs[i].s, vecs[i].r),
                {3'b0, an, ca, dp_out, 1'b0},
                {3'b0, vecs[i].exp_an, vecs[i].exp_ca, vecs[i].exp_dp, 1'b0});
        end

        // frame_done: one pulse per 64 cycles, the cycle after each boundary.
        bad = 0; pulses = 0;
        for (int k = 0; k < 128; k++) begin
            tick();
            if (frame_done !== ((cyc % 64) == 0)) bad++;
            if (frame_done === 1'b1) pulses++;
        end
        chk("frame_done_phase_errors", 16'(bad), 16'd0);
        chk("frame_done_pulses", 16'(pulses), 16'd2);

        // Shadowing plus repeated loads: mid-frame loads stay hidden, last wins.
        lz_sup = 1'b0; bright = 2'd3;
        do_load(16'h1234, 4'h0, 4'h0, fs);
        wait_until(fs + 20);
        do_load(16'h5555, 4'h0, 4'h0, bad);
        wait_until(fs + 30);
        do_load(16'hAAAA, 4'h0, 4'h0, bad);
        wait_until(fs + 2*16 + 5 + 1);
        chk("shadow_old_d2", {5'b0, an, ca}, {5'b0, 4'b1011, S2});
        wait_until(fs + 3*16 + 5 + 1);
        chk("shadow_old_d3", {5'b0, an, ca}, {5'b0, 4'b0111, S1});
        wait_until(fs + 64 + 5 + 1);
        chk("shadow_new_d0", {5'b0, an, ca}, {5'b0, 4'b1110, SA});
        wait_until(fs + 64 + 16 + 5 + 1);
        chk("shadow_new_d1", {5'b0, an, ca}, {5'b0, 4'b1101, SA});

        // Load in the boundary cycle overrides an earlier pending load.
        do_load(16'h1111, 4'h0, 4'h0, bad);
        while ((cyc % 64) != 63) tick();
        do_load(16'h6789, 4'h0, 4'h0, bad);
        fs = cyc;
        wait_until(fs + 5 + 1);
        chk("bnd_load_d0", {5'b0, an, ca}, {5'b0, 4'b1110, S9});
        wait_until(fs + 16 + 5 + 1);
        chk("bnd_load_d1", {5'b0, an, ca}, {5'b0, 4'b1101, S8});
        wait_until(fs + 64 + 5 + 1);
        chk("bnd_load_next_frame", {5'b0, an, ca}, {5'b0, 4'b1110, S9});

        // Reset mid-scan at idx=2, rcnt=7: outputs go inactive before any edge.
        while ((cyc % 64) != 39) tick();
        chk("pre_reset_lit", {5'b0, an, ca}, {5'b0, 4'b1011, S7});
        clr_n = 1'b0;
        #1;
        chk("async_reset", {3'b0, an, ca, dp_out, frame_done}, {3'b0, 4'b1111, OFF, 1'b1, 1'b0});
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;

        // Recovery: dark until the load reaches a frame boundary; scan restarts
        // at idx0/rcnt0 so the first frame_done lands exactly 64 edges later.
        lz_sup = 1'b0; bright = 2'd3;
        do_load(16'h1234, 4'h0, 4'h0, fs);
        bad = 0;
        while (cyc <= 64) begin
            if (an !== 4'b1111) bad++;
            if (frame_done !== (cyc == 64)) bad++;
            tick();
        end
        chk("recovery_dark_first_frame", 16'(bad), 16'd0);
        wait_until(66);
        chk("recovery_first_slot_idx0", {5'b0, an, ca}, {5'b0, 4'b1110, S4});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multi_dig_svn_seg_display.md
MULTI_DIG_SVN_SEG_DISPLAY -- requirements
Module: multi_dig_svn_seg_display

Interface
REQ-001 SHALL have parameter NUM_DIG, default 8: number of multiplexed digits; legal range 2..16.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot; must be a multiple of 2**BRIGHT_W and at least 2**BRIGHT_W.
REQ-003 SHALL have parameter BRIGHT_W, default 4: brightness code width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, as the following two port lines state.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 clr_n  input  1  asynchronous active-low reset.
REQ-007 digits  input  4*NUM_DIG  hex values; digits[4i+3:4i] belongs to digit i; digit 0 is the rightmost digit.
REQ-008 dp  input  NUM_DIG  decimal-point request per digit, active high.
REQ-009 blank  input  NUM_DIG  forced blank per digit, active high.
REQ-010 lz_sup  input  1  leading-zero suppression enable.
REQ-011 bright  input  BRIGHT_W  brightness code; 0 means off.
REQ-012 load  input  1  one-cycle strobe that captures digits, dp and blank.
REQ-013 an  output  NUM_DIG  anode enables, active low; an[i] drives digit i.
REQ-014 ca  output  7  cathodes, active low; ca[6:0] = {g,f,e,d,c,b,a}.
REQ-015 dp_out  output  1  decimal-point cathode, active low.
REQ-016 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-017 Refresh counter: rcnt counts 0..REFRESH_DIV-1, then wraps to 0; it counts every cycle.
REQ-018 Digit index: idx increments when rcnt==REFRESH_DIV-1 and wraps from NUM_DIG-1 to 0.
REQ-019 Frame boundary: the cycle in which rcnt==REFRESH_DIV-1 and idx==NUM_DIG-1.
REQ-020 Pending shadow set: load captures digits, dp and blank into it and sets pend_v.
REQ-021 Active set update: at a frame boundary with pend_v=1, the active set takes the pending set and pend_v clears.
REQ-022 Load at a frame boundary: the newly loaded values go straight into the active set, and pend_v is left 0.
REQ-023 Repeated loads within one frame: the last load wins.
REQ-024 Between frame boundaries the active set SHALL never change, so no digit shows mixed old and new data within a frame.
REQ-025 Sub-slot: sub = rcnt / (REFRESH_DIV >> BRIGHT_W).
REQ-026 Anode on condition: an[idx] is 0 only when rcnt != 0 (one-cycle anti-ghost gap) AND sub < bright AND the digit is not blanked.
REQ-027 Anode off condition: all other anodes are 1 at all times.
REQ-028 Brightness extremes: bright=0 gives an all 1s; the maximum code gives (2**BRIGHT_W-1)/2**BRIGHT_W duty, less the gap cycle.
REQ-029 Digit blanked if: the active blank[i] is 1, OR (lz_sup=1 AND i!=0 AND digit i and all higher digits in the active set are 0).
REQ-030 Digit 0 SHALL never be zero-suppressed.
REQ-031 Decimal point: dp_out = ~dp[idx] whenever an[idx] is driven 0; otherwise dp_out is 1.
REQ-032 Decimal point and suppression: dp is shown on a zero-suppressed digit only if that digit is not force-blanked.
REQ-033 Cathodes for a displayed digit: ca follows standard hex decoding, active low.
REQ-034 Hex decoding values: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-035 Cathodes when blanked: ca is 1111111 for a blanked digit and whenever all anodes are off.
REQ-036 Output registration: an, ca, dp_out and frame_done are registered, one cycle after the rcnt/idx state that produces them.
REQ-037 frame_done SHALL pulse high one cycle after each frame boundary.
REQ-038 bright and lz_sup SHALL take effect on the next cycle, with no shadowing.

Reset
REQ-039 Reset SHALL be asserted asynchronously by clr_n=0 and released synchronously to clk.
REQ-040 Reset values: rcnt=0, idx=0, active=0, pending=0, pend_v=0.
REQ-041 Reset values: an=all 1s, ca=1111111, dp_out=1, frame_done=0.
REQ-042 Reset mid-slot SHALL force all outputs to their reset values within the same cycle, without waiting for a clock edge.
REQ-043 After release, scanning SHALL restart at digit 0 with rcnt=0.

Verification (NUM_DIG=4, REFRESH_DIV=16, BRIGHT_W=2)
REQ-044 Scan order: load digits=16'h1234, bright=3, lz_sup=0 -> after a frame boundary, slot idx0 shows an=1110, ca=0011001 ("4") for rcnt 1..11.
REQ-045 Scan order, continued: an=1111 at rcnt 0 and 12..15; then idx1 shows "3", and so on; frame_done pulses every 64 cycles.
REQ-046 Leading-zero suppression: digits=16'h0050, lz_sup=1 -> digits 3 and 2 have an=1111 throughout their slots; digit 1 shows "5"; digit 0 shows "0"; with digits=0, only digit 0 lights.
REQ-047 Shadowing: load 16'hAAAA mid-frame -> the display keeps its old values until the frame boundary, then all digits show "A".
REQ-048 Load at boundary: a load in the boundary cycle is visible in the next frame.
REQ-049 Brightness: bright=0 -> an=1111 for the whole frame.
REQ-050 Brightness: bright=1 -> an active only at rcnt 1..3 of each slot.
REQ-051 Blank and decimal point: blank=0100, dp=0101 -> digit 2 dark with dp_out=1; digit 0 has dp_out=0 while lit.
REQ-052 Reset mid-scan: assert clr_n=0 at idx=2, rcnt=7 -> an=1111, ca=1111111, dp_out=1 immediately.
REQ-053 Reset recovery: after release, the display is blank until a load plus a frame boundary, and the first slot after release is idx0.
